// File: rtl/line_clear_engine.sv
// Line-clear engine: scans the playfield bottom-up through a 1-cycle row RAM port,
// drops full rows by compacting survivors downward, then zero-fills the vacated top rows.
module line_clear_engine #(
  parameter int unsigned BLOCKS_W   = 10,
  parameter int unsigned BLOCKS_H   = 20,
  parameter bit          EARLY_EXIT = 1'b1,
  localparam int unsigned ROW_W     = $clog2(BLOCKS_H),
  localparam int unsigned CNT_W     = $clog2(BLOCKS_H + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    lines_cleared,
  output logic [BLOCKS_H-1:0] full_row_mask,
  output logic                rd_en,
  output logic [ROW_W-1:0]    rd_addr,
  input  logic [BLOCKS_W-1:0] rd_data,
  output logic                wr_en,
  output logic [ROW_W-1:0]    wr_addr,
  output logic [BLOCKS_W-1:0] wr_data
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLOCKS_H - 1);

  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} state_t;

  state_t              state, state_n;
  logic [ROW_W-1:0]    rd_ptr, rd_ptr_n;
  logic [ROW_W-1:0]    wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [CNT_W-1:0]    fill_left, fill_n;
  logic [BLOCKS_H-1:0] mask, mask_n;
  logic                scan_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_ptr    <= LAST_ROW;
      wr_ptr    <= LAST_ROW;
      count     <= '0;
      fill_left <= '0;
      mask      <= '0;
    end else begin
      state     <= state_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      fill_left <= fill_n;
      mask      <= mask_n;
    end
  end

  // Next-state, datapath updates and RAM strobes; the write in EVAL must see rd_data this cycle.
  always_comb begin
    state_n  = state;
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    fill_n   = fill_left;
    mask_n   = mask;
    scan_end = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          rd_ptr_n = LAST_ROW;
          wr_ptr_n = LAST_ROW;
          count_n  = '0;
          mask_n   = '0;
          state_n  = READ;
        end
      end
      READ: begin
        rd_en   = 1'b1;
        rd_addr = rd_ptr;
        state_n = EVAL;
      end
      EVAL: begin
        if (&rd_data) begin
          count_n        = count + CNT_W'(1);
          mask_n[rd_ptr] = 1'b1;
        end else if (EARLY_EXIT && (rd_data == '0)) begin
          scan_end = 1'b1;
        end else begin
          if (wr_ptr != rd_ptr) begin
            wr_en   = 1'b1;
            wr_addr = wr_ptr;
            wr_data = rd_data;
          end
          if (wr_ptr != '0) wr_ptr_n = wr_ptr - ROW_W'(1);
        end
        if (scan_end || (rd_ptr == '0)) begin
          fill_n  = count_n;
          state_n = (count_n != '0) ? FILL : DONE;
        end else begin
          rd_ptr_n = rd_ptr - ROW_W'(1);
          state_n  = READ;
        end
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_addr = wr_ptr;
        if (wr_ptr != '0) wr_ptr_n = wr_ptr - ROW_W'(1);
        fill_n = fill_left - CNT_W'(1);
        if (fill_left == CNT_W'(1)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign lines_cleared = count;
  assign full_row_mask = mask;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: row RAM model, two DUTs (early exit on/off) sharing it,
// and a row-list reference model of the scan/compact/fill result.
module tb_line_clear_engine;

  localparam int unsigned W  = 10;
  localparam int unsigned H  = 20;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic reset, start, sel, load;
  logic [W-1:0] rd_data;

  logic busy0, busy1, done0, done1, rd_en0, rd_en1, wr_en0, wr_en1;
  logic [RW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [W-1:0]  wr_data0, wr_data1;
  logic [CW-1:0] lines0, lines1;
  logic [H-1:0]  mask0, mask1;

  logic busy, done, rd_en, wr_en;
  logic [RW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  wr_data;
  logic [CW-1:0] lines;
  logic [H-1:0]  mask;

  logic [W-1:0] ram [H];
  logic [W-1:0] load_board [H];
  logic [W-1:0] exp_board [H];
  logic [H-1:0] exp_mask;
  int exp_lines, exp_cyc;
  int vectors = 0, miscompares = 0;
  int overlap = 0, done_cnt = 0;

  always #5 clk = ~clk;

  line_clear_engine #(.BLOCKS_W(W), .BLOCKS_H(H), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset(reset), .start(start & ~sel), .busy(busy0), .done(done0),
    .lines_cleared(lines0), .full_row_mask(mask0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data(rd_data), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  line_clear_engine #(.BLOCKS_W(W), .BLOCKS_H(H), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start(start & sel), .busy(busy1), .done(done1),
    .lines_cleared(lines1), .full_row_mask(mask1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  assign busy    = sel ? busy1    : busy0;
  assign done    = sel ? done1    : done0;
  assign rd_en   = sel ? rd_en1   : rd_en0;
  assign wr_en   = sel ? wr_en1   : wr_en0;
  assign rd_addr = sel ? rd_addr1 : rd_addr0;
  assign wr_addr = sel ? wr_addr1 : wr_addr0;
  assign wr_data = sel ? wr_data1 : wr_data0;
  assign lines   = sel ? lines1   : lines0;
  assign mask    = sel ? mask1    : mask0;

  // Row RAM with 1-cycle read latency, plus strobe-overlap and done-pulse monitors
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < H; i++) ram[i] <= load_board[i];
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= ram[rd_addr];
    if (rd_en && wr_en) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic load_now();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic set_spec_board();
    for (int i = 0; i < H; i++) load_board[i] = '0;
    load_board[19] = 10'h221;
    load_board[18] = 10'h3FF;
    load_board[17] = 10'h060;
    load_board[16] = 10'h3FF;
    load_board[15] = 10'h104;
    load_now();
  endtask

  task automatic rand_board();
    for (int r = 0; r < H; r++) begin
      int k = int'($urandom_range(7));
      if (k < 2)       load_board[r] = '1;
      else if (k == 2) load_board[r] = '0;
      else             load_board[r] = W'($urandom);
    end
    load_now();
  endtask

  // Reference: survivors keep order and stack at the bottom, one zero row per cleared line above them
  task automatic model(input bit ee);
    logic [W-1:0] kept [$];
    int n, s, w;
    n = 0; s = 0; exp_mask = '0;
    for (int r = H - 1; r >= 0; r--) begin
      s++;
      if (ram[r] == {W{1'b1}}) begin
        n++;
        exp_mask[r] = 1'b1;
      end else if (ee && ram[r] == '0) begin
        break;
      end else begin
        kept.push_back(ram[r]);
      end
    end
    for (int r = 0; r < H; r++) exp_board[r] = ram[r];
    w = H - 1;
    foreach (kept[i]) begin exp_board[w] = kept[i]; w--; end
    for (int i = 0; i < n; i++) begin exp_board[w] = '0; w--; end
    exp_lines = n;
    exp_cyc   = 2 * s + n + 1;
  endtask

  function automatic int board_diffs();
    int d = 0;
    for (int r = 0; r < H; r++) if (ram[r] !== exp_board[r]) d++;
    return d;
  endfunction

  // Pulse start, return the cycle done rose in (-1 on timeout) and whether IDLE follows
  task automatic run_pass(output int cyc, output bit idle_after);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin @(posedge clk); #1; cyc++; end
    if (!done) cyc = -1;
    @(posedge clk); #1;
    idle_after = !busy && !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0, lines0, mask0} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_ee got busy=%b done=%b rd=%b wr=%b lines=%0d mask=%h want all 0",
               busy0, done0, rd_en0, wr_en0, lines0, mask0);
    end
    vectors++;
    if ({busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1, lines1, mask1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_full got busy=%b done=%b lines=%0d mask=%h want all 0",
               busy1, done1, lines1, mask1);
    end
    reset = 1'b0;
  endtask

  task automatic test_spec_board();
    int cyc; bit idle; int ov;
    sel = 1'b0; set_spec_board(); model(1'b1); ov = overlap;
    run_pass(cyc, idle);
    vectors++; if (cyc !== 15) begin miscompares++; $display("FAIL spec_latency got %0d want 15", cyc); end
    vectors++; if (lines !== CW'(2)) begin miscompares++; $display("FAIL spec_lines got %0d want 2", lines); end
    vectors++; if (mask !== 20'h50000) begin miscompares++; $display("FAIL spec_mask got %h want 50000", mask); end
    vectors++; if (ram[18] !== 10'h060 || ram[17] !== 10'h104 || ram[16] !== '0 || ram[15] !== '0) begin
      miscompares++; $display("FAIL spec_rows got %h %h %h %h want 060 104 000 000", ram[18], ram[17], ram[16], ram[15]);
    end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL spec_board got %0d bad rows want 0", board_diffs()); end
    vectors++; if (overlap !== ov || idle !== 1'b1) begin
      miscompares++; $display("FAIL spec_strobes overlap=%0d idle=%b want 0 and 1", overlap - ov, idle);
    end
  endtask

  task automatic test_all_zero();
    int cyc; bit idle;
    sel = 1'b0;
    for (int i = 0; i < H; i++) load_board[i] = '0;
    load_now(); model(1'b1);
    run_pass(cyc, idle);
    vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL zero_latency got %0d want 3", cyc); end
    vectors++; if (lines !== '0 || mask !== '0) begin
      miscompares++; $display("FAIL zero_result got lines=%0d mask=%h want 0 0", lines, mask);
    end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL zero_board got %0d bad rows want 0", board_diffs()); end
  endtask

  task automatic test_all_full();
    int cyc; bit idle;
    sel = 1'b0;
    for (int i = 0; i < H; i++) load_board[i] = '1;
    load_now(); model(1'b1);
    run_pass(cyc, idle);
    vectors++; if (cyc !== 61) begin miscompares++; $display("FAIL full_latency got %0d want 61", cyc); end
    vectors++; if (lines !== CW'(20)) begin miscompares++; $display("FAIL full_lines got %0d want 20", lines); end
    vectors++; if (mask !== 20'hFFFFF) begin miscompares++; $display("FAIL full_mask got %h want fffff", mask); end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL full_board got %0d bad rows want 0", board_diffs()); end
  endtask

  task automatic test_no_early_exit();
    int cyc; bit idle;
    sel = 1'b1; set_spec_board(); model(1'b0);
    run_pass(cyc, idle);
    vectors++; if (cyc !== 43) begin miscompares++; $display("FAIL noexit_latency got %0d want 43", cyc); end
    vectors++; if (lines !== CW'(2) || mask !== 20'h50000) begin
      miscompares++; $display("FAIL noexit_result got lines=%0d mask=%h want 2 50000", lines, mask);
    end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL noexit_board got %0d bad rows want 0", board_diffs()); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, d0;
    sel = 1'b0; set_spec_board(); model(1'b1); d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      start = (cyc == 2 || cyc == 4 || cyc == 9);
      @(posedge clk); #1; cyc++;
    end
    if (!done) cyc = -1;
    start = 1'b1;
    vectors++; if (cyc !== 15) begin miscompares++; $display("FAIL b2b_latency got %0d want 15", cyc); end
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_done_start_ignored got busy=%b done=%b want 0 0", busy, done);
    end
    model(1'b1);
    @(posedge clk); #1 start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 400) begin @(posedge clk); #1; cyc++; end
    if (!done) cyc = -1;
    vectors++; if (cyc !== exp_cyc || lines !== CW'(exp_lines)) begin
      miscompares++; $display("FAIL b2b_second_pass got cyc=%0d lines=%0d want %0d %0d", cyc, lines, exp_cyc, exp_lines);
    end
    @(posedge clk); #1;
    vectors++; if (done_cnt - d0 !== 2) begin
      miscompares++; $display("FAIL b2b_done_pulses got %0d want 2", done_cnt - d0);
    end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL b2b_board got %0d bad rows want 0", board_diffs()); end
  endtask

  task automatic test_reset_midpass();
    int cyc; bit idle;
    sel = 1'b0; set_spec_board();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, lines, mask} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got busy=%b rd=%b rd_addr=%0d lines=%0d mask=%h want all 0",
               busy, rd_en, rd_addr, lines, mask);
    end
    @(posedge clk); #1 reset = 1'b0;
    set_spec_board(); model(1'b1);
    run_pass(cyc, idle);
    vectors++; if (cyc !== exp_cyc || lines !== CW'(exp_lines) || mask !== exp_mask) begin
      miscompares++; $display("FAIL midreset_rerun got cyc=%0d lines=%0d mask=%h want %0d %0d %h",
                              cyc, lines, mask, exp_cyc, exp_lines, exp_mask);
    end
    vectors++; if (board_diffs() !== 0) begin miscompares++; $display("FAIL midreset_board got %0d bad rows want 0", board_diffs()); end
  endtask

  task automatic test_random();
    int cyc, ov; bit idle;
    for (int t = 0; t < 12; t++) begin
      sel = t[0];
      rand_board(); model(!sel); ov = overlap;
      run_pass(cyc, idle);
      vectors++;
      if (cyc !== exp_cyc || lines !== CW'(exp_lines) || mask !== exp_mask || idle !== 1'b1) begin
        miscompares++;
        $display("FAIL rand%0d_result got cyc=%0d lines=%0d mask=%h idle=%b want %0d %0d %h 1",
                 t, cyc, lines, mask, idle, exp_cyc, exp_lines, exp_mask);
      end
      vectors++;
      if (board_diffs() !== 0 || overlap !== ov) begin
        miscompares++;
        $display("FAIL rand%0d_board got %0d bad rows overlap=%0d want 0 0", t, board_diffs(), overlap - ov);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    start = 1'b0; sel = 1'b0; load = 1'b0; reset = 1'b1;
    test_reset();
    test_spec_board();
    test_all_zero();
    test_all_full();
    test_no_early_exit();
    test_back_to_back();
    test_reset_midpass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
